// File: rtl/imem_fetch_arbiter.sv
// Round-robin sharing of one registered-read instruction memory among NUM_PE fetch units.
// Optional upper-PC range check (error response with NOP) enabled by IMEM_ARB_ADDR_CHECK_EN.
module imem_fetch_arbiter #(
  parameter int          NUM_PE    = 4,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PE-1:0]    pe_req,
  input  logic [NUM_PE*32-1:0] pe_pc,
  input  logic [NUM_PE-1:0]    pe_flush,
  output logic [NUM_PE-1:0]    pe_gnt,
  output logic [NUM_PE*32-1:0] pe_instr,
  output logic [NUM_PE-1:0]    pe_instr_valid,
  output logic [NUM_PE-1:0]    rsp_err,
  output logic                 mem_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [31:0]          mem_rdata
);
  localparam int PTR_W = $clog2(NUM_PE);

  logic [PTR_W-1:0]  ptr_q;
  logic [NUM_PE-1:0] elig_p0;
  logic [PTR_W-1:0]  cand_p0;
  logic              gnt_vld_p0;
  logic [PTR_W-1:0]  gnt_idx_p0;
  logic [31:0]       pc_p0;
  logic              err_p0;
  logic              vld_p1;
  logic [PTR_W-1:0]  tag_p1;
  logic [NUM_PE-1:0] wr_p1;
  logic [31:0]       rsp_data_p1;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PE) s = s - NUM_PE;
    return PTR_W'(s);
  endfunction

  // Stage p0: arbitration and memory issue
  always_comb begin
    elig_p0    = pe_req & ~pe_flush;
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    cand_p0    = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      cand_p0 = rr_idx(ptr_q, i);
      if (!gnt_vld_p0 && elig_p0[cand_p0]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = cand_p0;
      end
    end
    gnt_vld_p0 = gnt_vld_p0 & rst_n;
  end

  always_comb begin
    pc_p0  = '0;
    pe_gnt = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (gnt_idx_p0 == PTR_W'(k)) pc_p0 = pe_pc[32*k +: 32];
      pe_gnt[k] = gnt_vld_p0 && (gnt_idx_p0 == PTR_W'(k));
    end
  end

  assign mem_addr = pc_p0[ADDR_W-1:0];
  assign mem_en   = gnt_vld_p0 & ~err_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        ptr_q <= (gnt_idx_p0 == PTR_W'(NUM_PE - 1)) ? '0 : gnt_idx_p0 + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_vld_p0) begin
      tag_p1 <= gnt_idx_p0;
    end
  end

  // Stage p1: memory data arrives; a flush of the owning PE kills the entry here
  always_comb begin
    wr_p1 = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      wr_p1[k] = vld_p1 && (tag_p1 == PTR_W'(k)) && !pe_flush[k];
    end
  end

`ifdef IMEM_ARB_ADDR_CHECK_EN
  logic err_p1;

  assign err_p0 = |pc_p0[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (gnt_vld_p0) begin
      err_p1 <= err_p0;
    end
  end

  assign rsp_data_p1 = err_p1 ? NOP_INSTR : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= '0;
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        if (wr_p1[k]) rsp_err[k] <= err_p1;
      end
    end
  end
`else
  logic unused_pc_hi;

  assign err_p0       = 1'b0;
  assign unused_pc_hi = ^pc_p0[31:ADDR_W];
  assign rsp_data_p1  = mem_rdata;
  assign rsp_err      = '0;
`endif

  // Stage p2: per-PE instruction slots and one-cycle valid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_instr_valid <= '0;
      pe_instr       <= '0;
    end else begin
      pe_instr_valid <= wr_p1;
      for (int k = 0; k < NUM_PE; k++) begin
        if (wr_p1[k]) pe_instr[32*k +: 32] <= rsp_data_p1;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Scoreboard bench for imem_fetch_arbiter: round-robin model plus behavioural memory;
// expected responses are queued at grant time and retired when their valid cycle arrives.
module tb_imem_fetch_arbiter;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   pe_req = '0;
  logic [127:0] pe_pc = '0;
  logic [3:0]   pe_flush = '0;
  logic [3:0]   pe_gnt;
  logic [127:0] pe_instr;
  logic [3:0]   pe_instr_valid;
  logic [3:0]   rsp_err;
  logic         mem_en;
  logic [7:0]   mem_addr;
  logic [31:0]  mem_rdata = '0;

  imem_fetch_arbiter #(.NUM_PE(4), .ADDR_W(8), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pe_req(pe_req), .pe_pc(pe_pc), .pe_flush(pe_flush),
    .pe_gnt(pe_gnt), .pe_instr(pe_instr), .pe_instr_valid(pe_instr_valid),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int pe; logic [31:0] instr; logic err; int due; } exp_t;
  exp_t sb[$];

  int           n_cmp = 0;
  int           n_bad = 0;
  int           bptr = 0;
  logic [31:0]  pcs [4];
  logic [31:0]  exp_slot [4];
  logic [3:0]   exp_errv = '0;
  logic [3:0]   exp_gnt, exp_valid;
  logic         exp_mem_en;
  logic [7:0]   exp_addr;
  logic [127:0] exp_instr;

  task automatic model_reset();
    bptr = 0;
    sb.delete();
    for (int k = 0; k < 4; k++) exp_slot[k] = '0;
    exp_errv = '0;
  endtask

  // Drives one cycle of stimulus at a falling edge and advances the reference model.
  task automatic drive_cycle(input logic [3:0] req, input logic [3:0] flush);
    logic [3:0]  elig;
    logic [31:0] pc;
    int          g;
    exp_t        e;
    pe_req   = req;
    pe_flush = flush;
    pe_pc    = {pcs[3], pcs[2], pcs[1], pcs[0]};
    #1;
    elig = req & ~flush;
    g = -1;
    for (int i = 0; i < 4; i++)
      if (g < 0 && elig[(bptr + i) % 4]) g = (bptr + i) % 4;
    exp_gnt = '0; exp_mem_en = 1'b0; exp_addr = '0;
    if (g >= 0) begin
      exp_gnt[g] = 1'b1;
      bptr = (g + 1) % 4;
      pc = pcs[g];
      e.pe = g; e.due = cyc + 2;
      if (CHK && pc[31:8] != 24'h0) begin
        e.instr = NOP; e.err = 1'b1;
      end else begin
        exp_mem_en = 1'b1; exp_addr = pc[7:0];
        e.instr = mem[pc[7:0]]; e.err = 1'b0;
      end
      sb.push_back(e);
    end
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due == cyc + 1 && flush[sb[i].pe]) sb.delete(i);
    exp_valid = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_valid[sb[0].pe] = 1'b1;
      exp_slot[sb[0].pe]  = sb[0].instr;
      exp_errv[sb[0].pe]  = sb[0].err;
      void'(sb.pop_front());
    end
    for (int k = 0; k < 4; k++) exp_instr[32*k +: 32] = exp_slot[k];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pe_req = 4'hF; pe_flush = '0; pe_pc = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (pe_gnt !== 4'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", pe_gnt); end
      n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
      n_cmp++; if ({pe_instr, pe_instr_valid, rsp_err} !== 136'h0) begin
        n_bad++; $display("FAIL reset_outputs: instr %h valid %b err %b want all 0", pe_instr, pe_instr_valid, rsp_err);
      end
    end
    @(negedge clk);
    pe_req = '0; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++) pcs[k] = 32'h10 * k + 32'h3;
    for (int c = 0; c < 9; c++) begin
      drive_cycle(c < 6 ? 4'hF : 4'h0, 4'h0);
      n_cmp++; if (pe_gnt !== exp_gnt) begin n_bad++; $display("FAIL rr_gnt c%0d: got %b want %b", c, pe_gnt, exp_gnt); end
      if (c < 6) begin
        n_cmp++; if (pe_gnt !== (4'b0001 << (c % 4))) begin n_bad++; $display("FAIL rr_order c%0d: got %b want %b", c, pe_gnt, 4'b0001 << (c % 4)); end
      end
      n_cmp++; if (pe_instr_valid !== exp_valid) begin n_bad++; $display("FAIL rr_valid c%0d: got %b want %b", c, pe_instr_valid, exp_valid); end
      n_cmp++; if (pe_instr !== exp_instr) begin n_bad++; $display("FAIL rr_instr c%0d: got %h want %h", c, pe_instr, exp_instr); end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    pcs[2] = 32'd5;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(c == 0 ? 4'b0100 : 4'b0000, 4'h0);
      if (c == 0) begin
        n_cmp++; if (pe_gnt !== 4'b0100 || mem_addr !== 8'd5 || mem_en !== 1'b1) begin
          n_bad++; $display("FAIL single_issue: gnt %b addr %0d en %b want 0100 5 1", pe_gnt, mem_addr, mem_en);
        end
      end
      n_cmp++; if (pe_instr_valid !== (c == 2 ? 4'b0100 : 4'b0000)) begin
        n_bad++; $display("FAIL single_valid c%0d: got %b", c, pe_instr_valid);
      end
      if (c >= 2) begin
        n_cmp++; if (pe_instr[95:64] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_slot2 c%0d: got %h want deadbeef", c, pe_instr[95:64]); end
      end
      n_cmp++; if (pe_instr !== exp_instr) begin n_bad++; $display("FAIL single_instr c%0d: got %h want %h", c, pe_instr, exp_instr); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    logic [3:0]  rq [8];
    logic [3:0]  fl [8];
    logic [31:0] slot1_before;
    rq = '{4'b0010, 4'b1000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    fl = '{4'b0000, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    pcs[0] = 32'd70; pcs[1] = 32'd71; pcs[3] = 32'd73;
    slot1_before = exp_slot[1];
    for (int c = 0; c < 8; c++) begin
      drive_cycle(rq[c], fl[c]);
      n_cmp++; if (pe_gnt !== exp_gnt) begin n_bad++; $display("FAIL flush_gnt c%0d: got %b want %b", c, pe_gnt, exp_gnt); end
      n_cmp++; if (pe_instr_valid !== exp_valid) begin n_bad++; $display("FAIL flush_valid c%0d: got %b want %b", c, pe_instr_valid, exp_valid); end
      n_cmp++; if (pe_instr !== exp_instr) begin n_bad++; $display("FAIL flush_instr c%0d: got %h want %h", c, pe_instr, exp_instr); end
      if (c == 2) begin
        n_cmp++; if (pe_gnt !== 4'b0000 || pe_instr_valid !== 4'b0000 || pe_instr[63:32] !== slot1_before) begin
          n_bad++; $display("FAIL flush_kill: gnt %b valid %b slot1 %h want 0000 0000 %h", pe_gnt, pe_instr_valid, pe_instr[63:32], slot1_before);
        end
      end
      if (c == 3) begin
        n_cmp++; if (pe_instr_valid !== 4'b1000) begin n_bad++; $display("FAIL flush_pe3_ret: got %b want 1000", pe_instr_valid); end
      end
      if (c == 5) begin
        n_cmp++; if (pe_instr_valid !== 4'b0001) begin n_bad++; $display("FAIL flush_late: got %b want 0001", pe_instr_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin
      pcs[0] = (c == 0) ? 32'd10 : 32'd11;
      drive_cycle(c < 2 ? 4'b0001 : 4'b0000, 4'h0);
      n_cmp++; if (pe_gnt !== (c < 2 ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL b2b_gnt c%0d: got %b", c, pe_gnt); end
      n_cmp++; if (pe_instr_valid !== exp_valid) begin n_bad++; $display("FAIL b2b_valid c%0d: got %b want %b", c, pe_instr_valid, exp_valid); end
      if (c == 2 || c == 3) begin
        n_cmp++; if (pe_instr_valid !== 4'b0001 || pe_instr[31:0] !== mem[c == 2 ? 10 : 11]) begin
          n_bad++; $display("FAIL b2b_data c%0d: valid %b slot0 %h want 0001 %h", c, pe_instr_valid, pe_instr[31:0], mem[c == 2 ? 10 : 11]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rq [6];
    logic [3:0] want [3];
    rq   = '{4'b1000, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    want = '{4'b1000, 4'b0001, 4'b1000};
    pcs[0] = 32'd20; pcs[3] = 32'd40;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(rq[c], 4'h0);
      if (c < 3) begin
        n_cmp++; if (pe_gnt !== want[c]) begin n_bad++; $display("FAIL wrap_gnt c%0d: got %b want %b", c, pe_gnt, want[c]); end
      end
      n_cmp++; if (pe_instr_valid !== exp_valid) begin n_bad++; $display("FAIL wrap_valid c%0d: got %b want %b", c, pe_instr_valid, exp_valid); end
      n_cmp++; if (pe_instr !== exp_instr) begin n_bad++; $display("FAIL wrap_instr c%0d: got %h want %h", c, pe_instr, exp_instr); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    pcs[1] = 32'd7; pcs[2] = 32'd9;
    drive_cycle(4'b0010, 4'h0);
    n_cmp++; if (pe_gnt !== exp_gnt) begin n_bad++; $display("FAIL mid_gnt0: got %b want %b", pe_gnt, exp_gnt); end
    @(negedge clk);
    drive_cycle(4'b0100, 4'h0);
    n_cmp++; if (pe_gnt !== exp_gnt) begin n_bad++; $display("FAIL mid_gnt1: got %b want %b", pe_gnt, exp_gnt); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({pe_gnt, mem_en} !== 5'b0) begin n_bad++; $display("FAIL mid_rst_issue: gnt %b en %b want 0", pe_gnt, mem_en); end
    n_cmp++; if ({pe_instr, pe_instr_valid, rsp_err} !== 136'h0) begin
      n_bad++; $display("FAIL mid_rst_out: instr %h valid %b err %b want 0", pe_instr, pe_instr_valid, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1; pe_req = '0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(c == 3 ? 4'hF : 4'h0, 4'h0);
      if (c == 3) begin
        n_cmp++; if (pe_gnt !== 4'b0001) begin n_bad++; $display("FAIL mid_ptr: got %b want 0001", pe_gnt); end
      end
      n_cmp++; if (pe_instr_valid !== exp_valid) begin n_bad++; $display("FAIL mid_valid c%0d: got %b want %b", c, pe_instr_valid, exp_valid); end
      n_cmp++; if (pe_instr !== exp_instr) begin n_bad++; $display("FAIL mid_instr c%0d: got %h want %h", c, pe_instr, exp_instr); end
      @(negedge clk);
    end
  endtask

  task automatic test_addr_width();
    pcs[0] = 32'h0000_0100;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(c == 0 ? 4'b0001 : 4'b0000, 4'h0);
      if (c == 0) begin
        n_cmp++; if (pe_gnt !== 4'b0001 || mem_en !== !CHK || (!CHK && mem_addr !== 8'h00)) begin
          n_bad++; $display("FAIL addr_issue: gnt %b en %b addr %h want 0001 %b 00", pe_gnt, mem_en, mem_addr, !CHK);
        end
      end
      if (c == 2) begin
        n_cmp++; if (pe_instr_valid !== 4'b0001 || pe_instr[31:0] !== (CHK ? NOP : mem[0]) || rsp_err[0] !== CHK) begin
          n_bad++; $display("FAIL addr_resp: valid %b slot0 %h err %b want 0001 %h %b", pe_instr_valid, pe_instr[31:0], rsp_err[0], CHK ? NOP : mem[0], CHK);
        end
      end
      n_cmp++; if (pe_instr_valid !== exp_valid) begin n_bad++; $display("FAIL addr_valid c%0d: got %b want %b", c, pe_instr_valid, exp_valid); end
      n_cmp++; if (pe_instr !== exp_instr) begin n_bad++; $display("FAIL addr_instr c%0d: got %h want %h", c, pe_instr, exp_instr); end
      n_cmp++; if (rsp_err !== exp_errv) begin n_bad++; $display("FAIL addr_err c%0d: got %b want %b", c, rsp_err, exp_errv); end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1357_0000 + i * 32'h0000_0101;
    mem[5] = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) pcs[k] = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_single();
    test_flush();
    test_back_to_back();
    test_wrap();
    test_reset_midflight();
    test_addr_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares one single-read-port instruction memory (1-cycle registered read) between NUM_PE processing elements (PEs).
- Round-robin arbitration; accepts one fetch per cycle, fully pipelined.
- Routes each returned instruction to the PE that requested it, with a one-cycle valid pulse.
- Sits between the PE fetch stages and the instruction memory array.

Parameters:
- NUM_PE, 4, number of requesting PEs (2..8).
- ADDR_W, 8, memory word-address width; depth is 2**ADDR_W 32-bit words.
- NOP_INSTR, 32'h00000013, instruction returned on flagged/error fetches.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pe_req  in  NUM_PE  per-PE fetch request, level; held until granted.
- pe_pc  in  NUM_PE*32  flattened word-indexed PCs; PE k uses bits [32k+31:32k].
- pe_flush  in  NUM_PE  per-PE flush; cancels that PE's in-flight fetch.
- pe_gnt  out  NUM_PE  one-hot grant, combinational, same cycle as issue.
- pe_instr  out  NUM_PE*32  flattened per-PE instruction slots, registered.
- pe_instr_valid  out  NUM_PE  one-cycle pulse: new instruction in slot k.
- rsp_err  out  NUM_PE  per-PE error flag, qualified by pe_instr_valid.
- mem_en  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en.

Behaviour:
- Reset (async assert, sync deassert):
  - pe_instr = 0, pe_instr_valid = 0, rsp_err = 0.
  - Round-robin pointer = 0; both pipeline stages empty.
  - pe_gnt and mem_en = 0 while rst_n is low.
- Eligibility:
  - Eligible set = pe_req & ~pe_flush.
  - Grant the first eligible PE at or after the pointer, wrapping NUM_PE-1 -> 0.
  - No eligible PE: pe_gnt = 0, mem_en = 0, pointer unchanged.
- Issue (cycle N, grant to PE g):
  - pe_gnt[g] = 1, mem_en = 1, mem_addr = pe_pc[g][ADDR_W-1:0].
  - At the edge ending N: pointer <= (g+1) mod NUM_PE; stage-1 captures {valid, tag = g}.
- Requester contract:
  - A PE holds pe_req and pe_pc stable until it sees pe_gnt.
  - It may re-request in the cycle after the grant; the next grant still obeys round-robin.
- Capture (cycle N+1):
  - Stage-2 captures stage-1; at the edge ending N+1, pe_instr slot tag <= mem_rdata.
- Response (cycle N+2):
  - pe_instr_valid[tag] = 1 for exactly one cycle.
  - The slot holds its value until that PE's next response; other slots are untouched.
- Latency and throughput:
  - Grant to valid is 2 cycles.
  - Sustained rate is 1 fetch/cycle; two fetches for the same PE may be in flight back-to-back.
- Flush:
  - pe_flush[k] in cycle N+1 (stage-1 holds tag k) kills that entry: no slot write, no valid.
  - Flush in N masks k from arbitration that cycle.
  - Flush in N+2 does not retract a valid pulse already asserted.
- Fairness: with all PEs continuously requesting, grants rotate 0,1,2,3,0,... Any requesting PE is granted within NUM_PE cycles.
- Reset mid-operation: in-flight entries are discarded; no valid pulse follows reset release.
- Width rule: PC bits above ADDR_W are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: IMEM_ARB_ADDR_CHECK_EN.
- Defined:
  - A granted fetch whose pe_pc[g][31:ADDR_W] != 0 still consumes the grant slot, but drives mem_en = 0.
  - The response (cycle N+2) carries pe_instr[g] = NOP_INSTR and rsp_err[g] = 1.
  - Flush rules apply unchanged.
- Undefined: upper PC bits are truncated and rsp_err is tied to 0.

Test Plan:
- Reset, then single request: PE2 pc=5, mem[5]=32'hDEADBEEF -> pe_gnt=4'b0100 and mem_addr=5 in cycle N; pe_instr slot2=DEADBEEF and pe_instr_valid=4'b0100 in N+2 only.
- All four PEs request continuously after reset -> grant order 0,1,2,3,0,1; one valid per cycle from cycle 2; each slot holds its own mem[pc].
- PE1 granted at cycle N, pe_flush[1]=1 in N+1 -> no valid for PE1 and slot1 unchanged; PE3's fetch in N+1 returns normally in N+3.
- rst_n pulsed low for one cycle while 2 fetches are in flight -> all outputs 0; no valid pulses after release; pointer back to 0.
- Only PE3 requests, then PE0 and PE3 request together -> PE3, then PE0 (pointer wrapped to 0), then PE3.
- With IMEM_ARB_ADDR_CHECK_EN: PE0 pc=32'h00000100 -> mem_en=0; in N+2 pe_instr slot0=32'h00000013 and rsp_err[0]=1. Without the macro: mem_addr=0 and rsp_err=0.
